// File: rtl/rom_prefetch.sv
// Sequential ROM fetch stage: issues addresses, absorbs the 1-clock ROM latency and queues bytes with their addresses.
// Optional macro ROM_PREFETCH_BYPASS_EN lets an in-flight response reach the consumer combinationally when the queue is empty.
module rom_prefetch #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    QDEPTH_LOG2 = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   output logic [ADDR_WIDTH-1:0]  ROM_A,
   output logic                   ROM_CS,
   input  logic [DATA_WIDTH-1:0]  ROM_DO,
   input  logic                   LOAD,
   input  logic [ADDR_WIDTH-1:0]  LOAD_ADDR,
   output logic [DATA_WIDTH-1:0]  OUT_DATA,
   output logic [ADDR_WIDTH-1:0]  OUT_ADDR,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [QDEPTH_LOG2:0]   LEVEL
);

   localparam int                 QD    = 1 << QDEPTH_LOG2;
   localparam logic [QDEPTH_LOG2:0] QFULL = (QDEPTH_LOG2+1)'(QD);

   logic [ADDR_WIDTH-1:0]  fptr, raddr;
   logic                   pend;
   logic [QDEPTH_LOG2:0]   level;
   logic [QDEPTH_LOG2-1:0] wptr, rptr;
   logic [DATA_WIDTH-1:0]  mem_data [QD];
   logic [ADDR_WIDTH-1:0]  mem_addr [QD];
   logic [QDEPTH_LOG2:0]   credit_used;
   logic                   issue, push, pop, q_empty;

   // Credits count queued entries plus the one response that may be in flight,
   // so a push can never find the queue full.
   assign credit_used = level + {{QDEPTH_LOG2{1'b0}}, pend};
   assign q_empty     = (level == '0);
   assign issue       = RESET_N && !LOAD && (credit_used < QFULL);
   assign pop         = !q_empty && OUT_READY && !LOAD;

   assign ROM_A  = fptr;
   assign ROM_CS = issue;
   assign LEVEL  = level;

`ifdef ROM_PREFETCH_BYPASS_EN
   logic byp;
   assign byp       = q_empty && pend && !LOAD;
   assign push      = pend && !LOAD && !(byp && OUT_READY);
   assign OUT_VALID = !q_empty || byp;
   assign OUT_DATA  = byp ? ROM_DO : mem_data[rptr];
   assign OUT_ADDR  = byp ? raddr  : mem_addr[rptr];
`else
   assign push      = pend && !LOAD;
   assign OUT_VALID = !q_empty;
   assign OUT_DATA  = mem_data[rptr];
   assign OUT_ADDR  = mem_addr[rptr];
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         fptr  <= RESET_ADDR;
         raddr <= '0;
         pend  <= 1'b0;
         level <= '0;
         wptr  <= '0;
         rptr  <= '0;
         for (int i = 0; i < QD; i++) begin
            mem_data[i] <= '0;
            mem_addr[i] <= '0;
         end
      end else if (LOAD) begin
         // Redirect drops everything queued and the response still in flight.
         fptr  <= LOAD_ADDR;
         pend  <= 1'b0;
         level <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         pend <= issue;
         if (issue) begin
            fptr  <= fptr + 1'b1;
            raddr <= fptr;
         end
         if (push) begin
            mem_data[wptr] <= ROM_DO;
            mem_addr[wptr] <= raddr;
            wptr           <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_prefetch.sv
// Randomised bench for rom_prefetch against a queue-level model of the fetch stream.
module tb_rom_prefetch;

   logic       CLK, RESET_N;
   logic [7:0] ROM_A, LOAD_ADDR, OUT_DATA, OUT_ADDR;
   logic       ROM_CS, LOAD, OUT_VALID, OUT_READY;
   logic [7:0] rom_do;
   logic [2:0] LEVEL;

   rom_prefetch dut (
      .CLK(CLK), .RESET_N(RESET_N), .ROM_A(ROM_A), .ROM_CS(ROM_CS), .ROM_DO(rom_do),
      .LOAD(LOAD), .LOAD_ADDR(LOAD_ADDR), .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .LEVEL(LEVEL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous ROM, mem[i] = i ^ 0x5A, its own reset value is 0xFF.
   always @(posedge CLK or negedge RESET_N)
      if (!RESET_N)    rom_do <= 8'hFF;
      else if (ROM_CS) rom_do <= ROM_A ^ 8'h5A;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Model: queue of addresses awaiting the consumer, plus one optional in-flight read.
   logic [7:0] mq[$];
   bit         m_pend;
   logic [7:0] m_paddr, m_fptr;

   task automatic model_reset();
      mq.delete();
      m_pend  = 0;
      m_paddr = 8'h00;
      m_fptr  = 8'h00;
   endtask

   task automatic model_step(input logic ld, input logic [7:0] la, input logic rdy);
      bit iss, byp_take;
      if (ld) begin
         mq.delete();
         m_pend = 0;
         m_fptr = la;
      end else begin
         iss      = (mq.size() + int'(m_pend)) < 4;
         byp_take = 0;
`ifdef ROM_PREFETCH_BYPASS_EN
         byp_take = (mq.size() == 0) && m_pend && rdy;
`endif
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (m_pend && !byp_take) mq.push_back(m_paddr);
         m_pend = iss;
         if (iss) begin
            m_paddr = m_fptr;
            m_fptr  = m_fptr + 8'h01;
         end
      end
   endtask

   task automatic compare(input logic ld);
      bit         ev;
      logic [7:0] ea;
      ev = mq.size() > 0;
      ea = ev ? mq[0] : 8'h00;
`ifdef ROM_PREFETCH_BYPASS_EN
      if (!ev && m_pend && !ld) begin
         ev = 1;
         ea = m_paddr;
      end
`endif
      chk("rom_cs", ROM_CS, !ld && ((mq.size() + int'(m_pend)) < 4));
      chk("rom_a", ROM_A, m_fptr);
      chk("level", LEVEL, mq.size());
      chk("out_valid", OUT_VALID, ev);
      if (ev) begin
         chk("out_addr", OUT_ADDR, ea);
         chk("out_data", OUT_DATA, ea ^ 8'h5A);
      end
   endtask

   // Entered just after a falling edge; returns just after the next one.
   task automatic cycle(input logic ld, input logic [7:0] la, input logic rdy);
      LOAD = ld; LOAD_ADDR = la; OUT_READY = rdy;
      #1 compare(ld);
      @(posedge CLK);
      model_step(ld, la, rdy);
      @(negedge CLK);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", OUT_VALID, 0);
      chk("rst_level", LEVEL, 0);
      chk("rst_cs", ROM_CS, 0);
      chk("rst_data", OUT_DATA, 0);
      chk("rst_addr", OUT_ADDR, 0);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0; LOAD = 1'b0; OUT_READY = 1'b0;
      #1 chk_reset_outputs();
      model_reset();
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin
      RESET_N = 1'b0; LOAD = 1'b0; LOAD_ADDR = 8'h00; OUT_READY = 1'b0;
      model_reset();
      @(negedge CLK);

      // Stream from reset with the consumer always ready.
      do_reset();
      repeat (12) cycle(0, 8'h00, 1);

      // Backpressure until full, then drain.
      do_reset();
      repeat (8) cycle(0, 8'h00, 0);
      repeat (10) cycle(0, 8'h00, 1);

      // Address wrap.
      cycle(1, 8'hFE, 1);
      repeat (8) cycle(0, 8'h00, 1);

      // Redirect while the read of 0x03 is in flight.
      do_reset();
      for (int i = 0; i < 10 && !(m_pend && m_paddr == 8'h03); i++) cycle(0, 8'h00, 1);
      chk("pend03_reached", m_pend && m_paddr == 8'h03, 1);
      cycle(1, 8'h80, 1);
      repeat (6) cycle(0, 8'h00, 1);

      // Asynchronous reset mid-stream with three entries queued.
      do_reset();
      for (int i = 0; i < 10 && mq.size() != 3; i++) cycle(0, 8'h00, 0);
      chk("level3_reached", mq.size(), 3);
      OUT_READY = 1'b0;
      #1 RESET_N = 1'b0;
      #1 chk_reset_outputs();
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (8) cycle(0, 8'h00, 1);

      // Random redirects and backpressure.
      for (int i = 0; i < 500; i++)
         cycle($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 3) != 0);

      // Redirect to 0x10 with a ready consumer.
      cycle(1, 8'h10, 1);
      repeat (6) cycle(0, 8'h00, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
